// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Purpose  : Shared UART receiver types, constants and the mid-bit check helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam int PRESCALE_MIN = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Check point sits after three samples centred on Prescale/2.
    function automatic logic [5:0] chk_edge(input logic [5:0] prescale);
        return (prescale >> 1) + 6'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fsm_if
// Purpose  : Line, counter and checker/deserializer signals of the RX sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_fsm_if #(
    parameter int DATA_WIDTH = 8
);
    logic                          RX_IN;
    logic                          PAR_EN;
    logic [5:0]                    Prescale;
    logic [5:0]                    edge_cnt;
    logic [$clog2(DATA_WIDTH):0]   bit_cnt;
    logic                          strt_glitch;
    logic                          par_err;
    logic                          stp_err;
    logic                          cnt_enable;
    logic                          dat_samp_en;
    logic                          deser_en;
    logic                          strt_chk_en;
    logic                          par_chk_en;
    logic                          stp_chk_en;
    logic                          data_valid;
    logic                          rx_err;
    logic                          break_det;

    modport master (
        input  RX_IN, PAR_EN, Prescale, edge_cnt, bit_cnt,
               strt_glitch, par_err, stp_err,
        output cnt_enable, dat_samp_en, deser_en, strt_chk_en,
               par_chk_en, stp_chk_en, data_valid, rx_err, break_det
    );

    modport slave (
        output RX_IN, PAR_EN, Prescale, edge_cnt, bit_cnt,
               strt_glitch, par_err, stp_err,
        input  cnt_enable, dat_samp_en, deser_en, strt_chk_en,
               par_chk_en, stp_chk_en, data_valid, rx_err, break_det
    );

endinterface
`default_nettype wire

// File: rtl/uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fsm
// Purpose  : UART receive sequencer (IDLE/START/DATA/PARITY/STOP) driving the
//            counter, sampler, deserializer and checker strobes.
// Options  : UART_RX_BREAK_DET_EN - all-zero frame with stop error reports break_det.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic      CLK,
    input  wire logic      RST,
    uart_rx_fsm_if.master  bus
);

    localparam int BCW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BCW-1:0] c_last_bit = BCW'(DATA_WIDTH);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_rst_sr;
    logic        r_par_en;
    logic        r_par_err;
    logic        r_data_valid;
    logic        r_rx_err;
    logic        w_rdy;
    logic        w_chk;
    logic        w_end;
    logic        w_cnt_en;
    logic        w_deser;
    logic        w_strt_chk;
    logic        w_par_chk;
    logic        w_stp_chk;
    logic        w_brk_hit;

    // Outputs stay quiet through reset and the first cycle after release.
    assign w_rdy = r_rst_sr[1];
    assign w_chk = (bus.edge_cnt == chk_edge(bus.Prescale));
    assign w_end = (bus.edge_cnt == (bus.Prescale - 6'd1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= ST_IDLE;
            r_rst_sr     <= 2'b00;
            r_par_en     <= 1'b0;
            r_par_err    <= 1'b0;
            r_data_valid <= 1'b0;
            r_rx_err     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rst_sr     <= {r_rst_sr[0], 1'b1};
            if (r_state == ST_IDLE) begin
                r_par_en  <= bus.PAR_EN;
                r_par_err <= 1'b0;
            end else if (w_par_chk) begin
                r_par_err <= bus.par_err;
            end
            r_data_valid <= w_stp_chk && !bus.stp_err && !r_par_err;
            r_rx_err     <= w_stp_chk && (bus.stp_err || r_par_err) && !w_brk_hit;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_en    = 1'b0;
        w_deser     = 1'b0;
        w_strt_chk  = 1'b0;
        w_par_chk   = 1'b0;
        w_stp_chk   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_rdy && !bus.RX_IN) begin
                    w_cnt_en    = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_cnt_en   = 1'b1;
                w_strt_chk = w_chk;
                if (w_chk && bus.strt_glitch) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_end) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_cnt_en = 1'b1;
                w_deser  = w_chk;
                if (w_end && (bus.bit_cnt == c_last_bit)) begin
                    w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                w_cnt_en  = 1'b1;
                w_par_chk = w_chk;
                if (w_end) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                w_cnt_en  = 1'b1;
                w_stp_chk = w_chk;
                // Leave at the check point: half a bit of slack for the next start edge.
                if (w_chk) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef UART_RX_BREAK_DET_EN
    logic r_all_zero;
    logic r_break_det;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_all_zero  <= 1'b0;
            r_break_det <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_all_zero <= 1'b1;
            end else if (w_deser) begin
                r_all_zero <= r_all_zero & ~bus.RX_IN;
            end
            r_break_det <= w_stp_chk && w_brk_hit;
        end
    end

    assign w_brk_hit     = r_all_zero & bus.stp_err;
    assign bus.break_det = r_break_det;
`else
    assign w_brk_hit     = 1'b0;
    assign bus.break_det = 1'b0;
`endif

    assign bus.cnt_enable  = w_cnt_en;
    assign bus.dat_samp_en = w_cnt_en;
    assign bus.deser_en    = w_deser;
    assign bus.strt_chk_en = w_strt_chk;
    assign bus.par_chk_en  = w_par_chk;
    assign bus.stp_chk_en  = w_stp_chk;
    assign bus.data_valid  = r_data_valid;
    assign bus.rx_err      = r_rx_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fsm
// Purpose  : Self-checking bench for uart_rx_fsm against a frame-timing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fsm;

    localparam int W = 8;
`ifdef UART_RX_BREAK_DET_EN
    localparam bit BRK = 1'b1;
`else
    localparam bit BRK = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    uart_rx_fsm_if #(.DATA_WIDTH(W)) bus ();

    uart_rx_fsm #(.DATA_WIDTH(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Sibling edge/bit counter as found in the RX top.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.edge_cnt <= '0;
            bus.bit_cnt  <= '0;
        end else if (!bus.cnt_enable) begin
            bus.edge_cnt <= '0;
            bus.bit_cnt  <= '0;
        end else if (bus.edge_cnt == bus.Prescale - 6'd1) begin
            bus.edge_cnt <= '0;
            bus.bit_cnt  <= bus.bit_cnt + 1'b1;
        end else begin
            bus.edge_cnt <= bus.edge_cnt + 6'd1;
        end
    end

    function automatic logic [8:0] outs();
        return {bus.cnt_enable, bus.dat_samp_en, bus.deser_en, bus.strt_chk_en,
                bus.par_chk_en, bus.stp_chk_en, bus.data_valid, bus.rx_err, bus.break_det};
    endfunction

    task automatic check(input string tag, input int cyc, input logic [8:0] obs, input logic [8:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s cyc %0d observed %b expected %b", tag, cyc, obs, req);
        end
    endtask

    task automatic hold_reset(input string tag);
        RST = 1'b0;
        #1 check({tag, " in_rst"}, 0, outs(), 9'd0);
        @(negedge CLK);
        #1 check({tag, " in_rst2"}, 0, outs(), 9'd0);
        RST        = 1'b1;
        bus.RX_IN  = 1'b0;
        #1 check({tag, " release"}, 0, outs(), 9'd0);
        @(negedge CLK);
        #1 check({tag, " first_cycle"}, 1, outs(), 9'd0);
        bus.RX_IN  = 1'b1;
        @(negedge CLK);
        #1 check({tag, " idle"}, 2, outs(), 9'd0);
    endtask

    task automatic idle(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            bus.RX_IN  = 1'b1;
            bus.PAR_EN = 1'($urandom);
            #1 check(tag, c, outs(), 9'd0);
        end
    endtask

    // Cycle 0 is the first low RX_IN cycle seen while IDLE; every later event
    // is placed by whole-bit arithmetic on the prescale.
    task automatic run_frame(input string tag, input int p, input bit pe, input logic [7:0] d,
                             input bit glitch, input bit perr, input bit serr, input bit brk,
                             input int abort_at);
        int   chk, t_stop, n_cyc, b;
        bit   zero_data, bad, bk;
        logic [8:0] exp_v;
        chk       = p / 2 + 1;
        t_stop    = glitch ? chk : p * (W + 1 + int'(pe)) + chk;
        n_cyc     = t_stop + 2;
        zero_data = brk || (d == 8'h00);
        bad       = serr || (pe && perr);
        bk        = BRK && zero_data && serr;
        bus.Prescale = 6'(p);
        for (int c = 0; c < n_cyc; c++) begin
            @(negedge CLK);
            b = c / p;
            if (c > t_stop)            bus.RX_IN = 1'b1;
            else if (glitch)           bus.RX_IN = (c < 2) ? 1'b0 : 1'b1;
            else if (brk)              bus.RX_IN = 1'b0;
            else if (b == 0)           bus.RX_IN = 1'b0;
            else if (b <= W)           bus.RX_IN = d[b-1];
            else if (pe && b == W + 1) bus.RX_IN = ^d;
            else                       bus.RX_IN = ~serr;
            bus.PAR_EN      = (c == 0) ? pe : 1'($urandom);
            bus.strt_glitch = (c == chk) ? glitch : 1'($urandom);
            bus.par_err     = (c == p * (W + 1) + chk) ? perr : 1'($urandom);
            bus.stp_err     = (c == t_stop) ? serr : 1'($urandom);
            if (c == abort_at) begin
                RST = 1'b0;
                #1 check({tag, " abort"}, c, outs(), 9'd0);
                hold_reset({tag, " after_abort"});
                return;
            end
            exp_v[8] = (c <= t_stop);
            exp_v[7] = (c <= t_stop);
            exp_v[6] = !glitch && c >= p && c < p * (W + 1) && (c % p) == chk;
            exp_v[5] = (c == chk);
            exp_v[4] = !glitch && pe && c == p * (W + 1) + chk;
            exp_v[3] = !glitch && c == t_stop;
            exp_v[2] = !glitch && c == t_stop + 1 && !bad;
            exp_v[1] = !glitch && c == t_stop + 1 && bad && !bk;
            exp_v[0] = !glitch && c == t_stop + 1 && bk;
            #1 check(tag, c, outs(), exp_v);
        end
    endtask

    initial begin
        int  p;
        logic [7:0] d;
        bus.RX_IN       = 1'b1;
        bus.PAR_EN      = 1'b0;
        bus.Prescale    = 6'd8;
        bus.strt_glitch = 1'b0;
        bus.par_err     = 1'b0;
        bus.stp_err     = 1'b0;
        @(negedge CLK);
        hold_reset("por");

        run_frame("p8_A5", 8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle("idle1", 3);
        run_frame("glitch", 8, 1'b0, 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, -1);
        idle("idle2", 2);
        run_frame("p16_parerr", 16, 1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, -1);
        idle("idle3", 2);
        run_frame("p32_b2b_00", 32, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_frame("p32_b2b_FF", 32, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_frame("abort", 8, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 4 * 8 + 3);
        run_frame("post_abort", 8, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle("idle4", 1);
        run_frame("break", 8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle("idle5", 2);

        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 2))
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            run_frame("rand", p, 1'($urandom), d, ($urandom_range(0, 7) == 0),
                      1'($urandom), 1'($urandom), 1'b0, -1);
            idle("rand_idle", $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Sequencing controller for the UART receiver.
- Detects the start condition and drives the edge/bit counter enable. Walks START/DATA/PARITY/STOP using the counter's edge_cnt/bit_cnt, and pulses the sampler, deserializer and start/parity/stop checker enables at the mid-bit check point.
- Issues data_valid for a clean frame, or rx_err for a dropped frame.
- Sits between RX_IN, the edge/bit counter and the checker/deserializer blocks inside the RX top.

Parameters:
- DATA_WIDTH, 8: data bits per frame; also sets the bit_cnt width.

Ports:
- CLK  in  1  receiver clock (Prescale x baud)
- RST  in  1  reset, asynchronous, active-low
- RX_IN  in  1  serial line, idle high
- PAR_EN  in  1  parity bit present
- Prescale  in  6  oversampling ratio; legal values 8, 16, 32
- edge_cnt  in  6  from the counter
- bit_cnt  in  $clog2(DATA_WIDTH)+1  from the counter
- strt_glitch  in  1  start checker result, valid the cycle strt_chk_en=1
- par_err  in  1  parity checker result, valid the cycle par_chk_en=1
- stp_err  in  1  stop checker result, valid the cycle stp_chk_en=1
- cnt_enable  out  1  counter enable
- dat_samp_en  out  1  data sampler enable
- deser_en  out  1  deserializer shift strobe
- strt_chk_en  out  1  start check strobe
- par_chk_en  out  1  parity check strobe
- stp_chk_en  out  1  stop check strobe
- data_valid  out  1  one-cycle pulse, frame accepted
- rx_err  out  1  one-cycle pulse, frame dropped (parity or stop error)
- break_det  out  1  see Optional Feature

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP. Binary encoded, registered.
- Definitions:
  - CHK = (Prescale>>1)+1. Check point is after 3 samples centred on Prescale/2.
  - END = (edge_cnt == Prescale-1), the last edge of a bit.
- Counter coupling:
  - The counter gives bit_cnt=0 during the start bit and 1..DATA_WIDTH on data bits.
  - The counter increments bit_cnt at END and clears both counts whenever cnt_enable=0.
- Reset: state=IDLE, par_en_q=0, par_err_q=0. All outputs 0 during reset and the first cycle after release.
- cnt_enable and dat_samp_en are combinational: 1 when state!=IDLE, or when state==IDLE and RX_IN==0. edge_cnt is therefore 0 on the first low cycle.
- IDLE:
  - RX_IN==0 -> START.
  - Latch par_en_q=PAR_EN and clear par_err_q. PAR_EN changes mid-frame are ignored.
- START:
  - strt_chk_en=1 when edge_cnt==CHK.
  - If strt_glitch=1 that cycle -> IDLE next. No error pulse.
  - Else END -> DATA.
- DATA:
  - deser_en=1 when edge_cnt==CHK, exactly DATA_WIDTH pulses per frame.
  - END with bit_cnt==DATA_WIDTH -> PARITY if par_en_q, else STOP.
- PARITY:
  - par_chk_en=1 at CHK; par_err_q <= par_err.
  - END -> STOP.
- STOP:
  - stp_chk_en=1 at CHK, then -> IDLE next cycle. The early return gives half-bit slack for back-to-back frames.
  - Registered outputs, next cycle: data_valid=1 iff !stp_err && !par_err_q; rx_err is the complement. Exactly one of the two pulses.
- Strobes: all *_chk_en and deser_en are combinational single-cycle decodes of state and edge_cnt.
- Async reset mid-frame: immediate IDLE, no data_valid or rx_err for the aborted frame.
- Prescale: values below 8 or not a power of two are unsupported; behaviour is undefined.
- RX_IN must not be sampled anywhere except in IDLE.

Optional Feature:
- Macro UART_RX_BREAK_DET_EN.
- When defined:
  - A sticky flag tracks that every deser_en sample was 0, using RX_IN sampled at CHK.
  - At the stop check, if the flag is set and stp_err=1, break_det pulses for one cycle in place of rx_err. data_valid=0.
- When undefined: break_det is tied to 0 and rx_err behaviour is unchanged.

Decomposition:
- Shared package uart_rx_pkg:
  - State typedef and encodings.
  - PRESCALE_MIN=8.
  - Function chk_edge(prescale) returning (prescale>>1)+1, reused by the sampler.
- No sub-module. The edge/bit counter stays a sibling instance in the RX top.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5, start detected at cycle 0:
  - 8 deser_en pulses at cycles 13, 21, …, 69.
  - stp_chk_en at cycle 77, IDLE at cycle 78, data_valid=1 only at cycle 78.
- RX_IN low 2 cycles, then high; strt_glitch=1 at edge_cnt=5 -> IDLE at cycle 6, no deser_en, no data_valid/rx_err.
- Prescale=16, PAR_EN=1, par_err=1 at par_chk_en -> rx_err one cycle after stp_chk_en, data_valid stays 0.
- Prescale=32, two back-to-back frames 0x00, 0xFF, with the second start edge 1 cycle after the first returns to IDLE -> two data_valid pulses; the second frame's counts start at edge_cnt=0.
- RST low during DATA at bit_cnt=4 -> all outputs 0 immediately. A following clean frame completes normally.
- With UART_RX_BREAK_DET_EN: RX_IN held low 12 bit times at Prescale=8 -> break_det pulse at cycle 78, rx_err=0, data_valid=0.
